// File: rtl/pe_regfile_sb_if.sv
// Bus between PE issue/writeback (master) and the register file (slave):
// write ports, read ports and the pending-write scoreboard.
interface pe_regfile_sb_if #(
   parameter int SCALAR_REGS  = 32,
   parameter int VECTOR_REGS  = 32,
   parameter int DATA_WIDTH   = 16,
   parameter int LANES        = 32,
   parameter int S_READ_PORTS = 2
);
   localparam int SAW       = $clog2(SCALAR_REGS);
   localparam int VAW       = $clog2(VECTOR_REGS);
   localparam int RAW       = (SAW > VAW) ? SAW : VAW;
   localparam int VEC_WIDTH = LANES * DATA_WIDTH;

   logic                             s_wr_en;
   logic [SAW-1:0]                   s_wr_addr;
   logic [DATA_WIDTH-1:0]            s_wr_data;
   logic [S_READ_PORTS*SAW-1:0]      s_rd_addr;
   logic [S_READ_PORTS*DATA_WIDTH-1:0] s_rd_data;
   logic                             v_wr_en;
   logic [VAW-1:0]                   v_wr_addr;
   logic [VEC_WIDTH-1:0]             v_wr_data;
   logic [LANES-1:0]                 v_wr_lane_mask;
   logic [VAW-1:0]                   v_rd_addr;
   logic [VEC_WIDTH-1:0]             v_rd_data;
   logic                             sb_rsv_en;
   logic                             sb_rsv_vec;
   logic [RAW-1:0]                   sb_rsv_addr;
   logic                             sb_rsv_ok;
   logic [SCALAR_REGS-1:0]           s_busy;
   logic [VECTOR_REGS-1:0]           v_busy;

   modport master (
      output s_wr_en, s_wr_addr, s_wr_data, s_rd_addr,
      output v_wr_en, v_wr_addr, v_wr_data, v_wr_lane_mask, v_rd_addr,
      output sb_rsv_en, sb_rsv_vec, sb_rsv_addr,
      input  s_rd_data, v_rd_data, sb_rsv_ok, s_busy, v_busy
   );

   modport slave (
      input  s_wr_en, s_wr_addr, s_wr_data, s_rd_addr,
      input  v_wr_en, v_wr_addr, v_wr_data, v_wr_lane_mask, v_rd_addr,
      input  sb_rsv_en, sb_rsv_vec, sb_rsv_addr,
      output s_rd_data, v_rd_data, sb_rsv_ok, s_busy, v_busy
   );
endinterface

// File: rtl/pe_regfile_sb.sv
// PE scalar/vector register file with write-first bypass, per-lane masked
// vector writes, optional hardwired-zero s0 and a pending-write scoreboard.
module pe_regfile_lane #(
   parameter int VECTOR_REGS = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int VAW         = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic [VAW-1:0]        i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [VAW-1:0]        i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);
   logic [DATA_WIDTH-1:0] r_mem [VECTOR_REGS];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < VECTOR_REGS; i++) r_mem[i] <= '0;
      end else if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // i_wr_en already includes the lane mask, so bypass yields the merged word
   assign o_rd_data = (i_wr_en && i_rd_addr == i_wr_addr) ? i_wr_data : r_mem[i_rd_addr];
endmodule

module pe_regfile_sb #(
   parameter int SCALAR_REGS  = 32,
   parameter int VECTOR_REGS  = 32,
   parameter int DATA_WIDTH   = 16,
   parameter int LANES        = 32,
   parameter int S_READ_PORTS = 2,
   parameter int ZERO_REG0    = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   pe_regfile_sb_if.slave bus
);
   localparam int SAW = $clog2(SCALAR_REGS);
   localparam int VAW = $clog2(VECTOR_REGS);

   logic [DATA_WIDTH-1:0] r_s_mem [SCALAR_REGS];
   logic [SCALAR_REGS-1:0] r_s_busy;
   logic [VECTOR_REGS-1:0] r_v_busy;

   logic w_s_we, w_v_we;
   logic [S_READ_PORTS-1:0][DATA_WIDTH-1:0] w_s_rd;
   logic [LANES-1:0][DATA_WIDTH-1:0]        w_v_rd;

   // Writes are gated by reset so nothing bypasses out while the file is cleared
   assign w_s_we = i_rst_n && bus.s_wr_en && !(ZERO_REG0 != 0 && bus.s_wr_addr == '0);
   assign w_v_we = i_rst_n && bus.v_wr_en;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < SCALAR_REGS; i++) r_s_mem[i] <= '0;
      end else if (w_s_we) begin
         r_s_mem[bus.s_wr_addr] <= bus.s_wr_data;
      end
   end

   always_comb begin
      w_s_rd = '0;
      for (int p = 0; p < S_READ_PORTS; p++) begin
         if (ZERO_REG0 != 0 && bus.s_rd_addr[p*SAW +: SAW] == '0)
            w_s_rd[p] = '0;
         else if (w_s_we && bus.s_rd_addr[p*SAW +: SAW] == bus.s_wr_addr)
            w_s_rd[p] = bus.s_wr_data;
         else
            w_s_rd[p] = r_s_mem[bus.s_rd_addr[p*SAW +: SAW]];
      end
   end
   assign bus.s_rd_data = w_s_rd;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      pe_regfile_lane #(
         .VECTOR_REGS(VECTOR_REGS), .DATA_WIDTH(DATA_WIDTH), .VAW(VAW)
      ) u_lane (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_wr_en   (w_v_we && bus.v_wr_lane_mask[l]),
         .i_wr_addr (bus.v_wr_addr),
         .i_wr_data (bus.v_wr_data[l*DATA_WIDTH +: DATA_WIDTH]),
         .i_rd_addr (bus.v_rd_addr),
         .o_rd_data (w_v_rd[l])
      );
   end
   assign bus.v_rd_data = w_v_rd;

   // Scoreboard: a release of the requested register in the same cycle lets the
   // reservation through, and the set wins so the bit stays busy.
   logic [SAW-1:0]         w_s_ra;
   logic [VAW-1:0]         w_v_ra;
   logic                   w_ok;
   logic [SCALAR_REGS-1:0] w_s_set, w_s_clr;
   logic [VECTOR_REGS-1:0] w_v_set, w_v_clr;

   assign w_s_ra = bus.sb_rsv_addr[SAW-1:0];
   assign w_v_ra = bus.sb_rsv_addr[VAW-1:0];

   always_comb begin
      w_ok    = 1'b0;
      w_s_set = '0;
      w_v_set = '0;
      w_s_clr = '0;
      w_v_clr = '0;
      if (i_rst_n && bus.sb_rsv_en) begin
         if (bus.sb_rsv_vec) begin
            w_ok = !r_v_busy[w_v_ra] || (bus.v_wr_en && bus.v_wr_addr == w_v_ra);
            w_v_set[w_v_ra] = w_ok;
         end else if (ZERO_REG0 != 0 && w_s_ra == '0) begin
            w_ok = 1'b1;
         end else begin
            w_ok = !r_s_busy[w_s_ra] || (bus.s_wr_en && bus.s_wr_addr == w_s_ra);
            w_s_set[w_s_ra] = w_ok;
         end
      end
      if (bus.s_wr_en) w_s_clr[bus.s_wr_addr] = 1'b1;
      if (bus.v_wr_en) w_v_clr[bus.v_wr_addr] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s_busy <= '0;
         r_v_busy <= '0;
      end else begin
         r_s_busy <= (r_s_busy & ~w_s_clr) | w_s_set;
         r_v_busy <= (r_v_busy & ~w_v_clr) | w_v_set;
      end
   end

   assign bus.sb_rsv_ok = w_ok;
   assign bus.s_busy    = r_s_busy;
   assign bus.v_busy    = r_v_busy;
endmodule

// File: tb/tb_pe_regfile_sb.sv
// Scoreboard bench for pe_regfile_sb: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pe_regfile_sb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pe_regfile_sb_if bus ();
   pe_regfile_sb dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

   typedef struct {
      int           cyc;
      int           kind;  // 0 s_rd p0, 1 s_rd p1, 2 v_rd, 3 ok, 4 s_busy, 5 v_busy
      logic [511:0] val;
      string        name;
   } exp_t;
   exp_t q[$];

   function automatic logic [511:0] actual(int k);
      logic [511:0] a = '0;
      case (k)
         0: a[15:0] = bus.s_rd_data[15:0];
         1: a[15:0] = bus.s_rd_data[31:16];
         2: a       = bus.v_rd_data;
         3: a[0]    = bus.sb_rsv_ok;
         4: a[31:0] = bus.s_busy;
         default: a[31:0] = bus.v_busy;
      endcase
      return a;
   endfunction

   function automatic logic [511:0] vfill(logic [15:0] v);
      logic [511:0] r;
      for (int i = 0; i < 32; i++) r[i*16 +: 16] = v;
      return r;
   endfunction

   exp_t         m_e;
   logic [511:0] m_act;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         m_e   = q.pop_front();
         m_act = actual(m_e.kind);
         checks++;
         if (m_e.cyc != cyc || m_act !== m_e.val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", m_e.name, cyc, m_act, m_e.val);
         end
      end
   end

   task automatic expn(int k, logic [511:0] v, string n);
      q.push_back('{cyc, k, v, n});
   endtask

   task automatic expnext(int k, logic [511:0] v, string n);
      q.push_back('{cyc + 1, k, v, n});
   endtask

   task automatic clear_inputs();
      bus.s_wr_en = 0; bus.s_wr_addr = '0; bus.s_wr_data = '0; bus.s_rd_addr = '0;
      bus.v_wr_en = 0; bus.v_wr_addr = '0; bus.v_wr_data = '0; bus.v_wr_lane_mask = '0;
      bus.v_rd_addr = '0; bus.sb_rsv_en = 0; bus.sb_rsv_vec = 0; bus.sb_rsv_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic swr(logic [4:0] a, logic [15:0] d);
      bus.s_wr_en = 1; bus.s_wr_addr = a; bus.s_wr_data = d;
   endtask

   task automatic rsv(logic vec, logic [4:0] a);
      bus.sb_rsv_en = 1; bus.sb_rsv_vec = vec; bus.sb_rsv_addr = a;
   endtask

   logic [511:0] merged;

   initial begin
      clear_inputs();
      merged = vfill(16'h0001);
      for (int i = 4; i < 8; i++) merged[i*16 +: 16] = 16'hAAAA;

      // reset held: write and reserve are discarded, nothing bypasses
      step(); swr(5'd3, 16'h1234); rsv(1'b0, 5'd4); bus.s_rd_addr = {5'd3, 5'd3};
      expn(0, 0, "rst_no_bypass"); expnext(4, 0, "rst_rsv_dropped");
      step(); rst_n = 1; bus.s_rd_addr = {5'd0, 5'd3};
      expn(0, 0, "s3_after_rst"); expn(1, 0, "s0_after_rst"); expn(2, 0, "v_after_rst");
      expn(4, 0, "sbusy_rst"); expn(5, 0, "vbusy_rst");

      step(); swr(5'd5, 16'hBEEF); bus.s_rd_addr = {5'd5, 5'd5};
      expn(0, 16'hBEEF, "byp_p0"); expn(1, 16'hBEEF, "byp_p1");
      step(); bus.s_rd_addr = {5'd5, 5'd5};
      expn(0, 16'hBEEF, "arr_p0"); expn(1, 16'hBEEF, "arr_p1");
      step(); swr(5'd0, 16'hFFFF); bus.s_rd_addr = {5'd5, 5'd0};
      expn(0, 0, "zero_byp"); expn(1, 16'hBEEF, "s5_p1");
      step(); bus.s_rd_addr = {5'd0, 5'd0};
      expn(0, 0, "zero_arr");

      // vector: full write, masked write, empty mask
      step(); bus.v_wr_en = 1; bus.v_wr_addr = 5'd2; bus.v_wr_data = vfill(16'h0001);
      bus.v_wr_lane_mask = '1; bus.v_rd_addr = 5'd2; rsv(1'b1, 5'd2);
      expn(2, vfill(16'h0001), "v_full_byp"); expn(3, 1, "rsv_v2_ok");
      expnext(5, 32'h4, "vbusy_v2");
      step(); bus.v_wr_en = 1; bus.v_wr_addr = 5'd2; bus.v_wr_data = vfill(16'hAAAA);
      bus.v_wr_lane_mask = 32'h0000_00F0; bus.v_rd_addr = 5'd2; rsv(1'b1, 5'd2);
      expn(2, merged, "v_mask_byp"); expn(3, 1, "rsv_v2_rel_ok");
      expnext(5, 32'h4, "vbusy_v2_keep");
      step(); bus.v_rd_addr = 5'd2;
      expn(2, merged, "v_mask_arr");
      step(); bus.v_wr_en = 1; bus.v_wr_addr = 5'd2; bus.v_wr_data = vfill(16'hFFFF);
      bus.v_wr_lane_mask = '0; bus.v_rd_addr = 5'd2;
      expn(2, merged, "v_mask0_byp"); expnext(5, 0, "vbusy_mask0_rel");
      step(); bus.v_rd_addr = 5'd2;
      expn(2, merged, "v_mask0_arr");

      // scalar scoreboard
      step(); rsv(1'b0, 5'd7);
      expn(3, 1, "rsv_s7"); expnext(4, 32'h80, "sbusy7");
      step(); rsv(1'b0, 5'd7);
      expn(3, 0, "rsv_s7_busy"); expnext(4, 32'h80, "sbusy7_hold");
      step(); swr(5'd7, 16'h7777); rsv(1'b0, 5'd7); bus.s_rd_addr = {5'd7, 5'd7};
      expn(3, 1, "rsv_s7_rel"); expn(0, 16'h7777, "s7_byp");
      expnext(4, 32'h80, "sbusy7_setprio");
      step(); swr(5'd7, 16'h1111);
      expnext(4, 0, "sbusy7_rel");
      step(); rsv(1'b0, 5'd9);
      expn(3, 1, "rsv_s9"); expnext(4, 32'h200, "sbusy9");
      step(); rsv(1'b1, 5'd9);
      expn(3, 1, "rsv_v9_indep"); expnext(5, 32'h200, "vbusy9");
      step(); rsv(1'b0, 5'd0);
      expn(3, 1, "rsv_s0_zero"); expnext(4, 32'h200, "sbusy0_stays0");
      step(); swr(5'd9, 16'h0009); rsv(1'b0, 5'd12);
      expn(3, 1, "rsv_s12_rel_s9"); expnext(4, 32'h1000, "sbusy12_only");

      // mid-stream reset with a reservation in the same cycle
      step(); rst_n = 0; rsv(1'b0, 5'd20);
      expnext(4, 0, "sbusy_midrst"); expnext(5, 0, "vbusy_midrst");
      step(); rst_n = 1; bus.s_rd_addr = {5'd7, 5'd5}; bus.v_rd_addr = 5'd2;
      expn(0, 0, "s5_midrst"); expn(1, 0, "s7_midrst"); expn(2, 0, "v2_midrst");
      step();

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         $display("FAIL drain pending=%0d want=0", q.size());
         errors += q.size();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
